// File: rtl/vinstr_queue.sv
// vinstr_queue: decoupling FIFO between the scalar core's vector-dispatch port
// and the vector unit's instruction input. Holds up to DEPTH entries, each a
// {fence, payload} pair. A fence at the head blocks younger instructions until
// the vector unit reports idle; the fence itself is never delivered.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   push_valid_i       scalar core offers an entry
//   push_data_i [DW]   instruction payload (ignored for fences)
//   push_fence_i       offered entry is a fence marker
//   push_ready_o       queue not full (registered)
//   flush_i            discard all entries on the next edge
//   valid_o            head instruction presented to the vector unit
//   instr_o [DW]       head payload
//   pop_i              vector unit consumes the head
//   vector_idle_i      vector unit idle
//   count_o [CNT_W]    occupied entries, fences included (registered)
//   empty_o            count_o == 0 (registered)
//
// Build option: define VINSTR_QUEUE_BYPASS_EN to present a non-fence push
// straight to the output in the same cycle while the queue is empty.

module vinstr_queue #(
  parameter int unsigned DW    = 128,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_valid_i,
  input  logic [DW-1:0]    push_data_i,
  input  logic             push_fence_i,
  output logic             push_ready_o,
  input  logic             flush_i,
  output logic             valid_o,
  output logic [DW-1:0]    instr_o,
  input  logic             pop_i,
  input  logic             vector_idle_i,
  output logic [CNT_W-1:0] count_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FullCnt = CNT_W'(DEPTH);

  typedef enum logic [0:0] {StWaitArm, StWaitIdle} state_e;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DEPTH-1:0] fence_q;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready_q, empty_q;
  logic [DW-1:0]    instr_q;
  state_e           state_q, state_d;

  logic head_valid, head_fence, bypass, do_push, do_pop, drop, remove;

  assign head_fence = !empty_q && fence_q[rd_ptr_q];
  assign head_valid = !empty_q && !fence_q[rd_ptr_q];

`ifdef VINSTR_QUEUE_BYPASS_EN
  assign bypass = empty_q && !flush_i && push_valid_i && !push_fence_i;
`else
  assign bypass = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    drop     = 1'b0;
    // The arm cycle gives a just-popped instruction time to clear vector_idle_i.
    if (head_fence) begin
      case (state_q)
        StWaitArm:  state_d = StWaitIdle;
        StWaitIdle: begin
          if (vector_idle_i) begin
            drop    = 1'b1;
            state_d = StWaitArm;
          end
        end
        default:    state_d = StWaitArm;
      endcase
    end

    do_pop  = pop_i && head_valid;
    // A bypassed entry consumed in the same cycle never enters storage.
    do_push = push_valid_i && ready_q && !flush_i && !(bypass && pop_i);
    remove  = do_pop || drop;

    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = remove  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({do_push, remove})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      state_d  = StWaitArm;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      empty_q  <= 1'b1;
      instr_q  <= '0;
      state_q  <= StWaitArm;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= (count_d != FullCnt);
      empty_q  <= (count_d == '0);
      state_q  <= state_d;
      if (valid_o) begin
        instr_q <= instr_o;
      end
    end
  end

  // Storage needs no reset: occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q]   <= push_data_i;
      fence_q[wr_ptr_q] <= push_fence_i;
    end
  end

  assign valid_o      = head_valid || bypass;
  assign instr_o      = bypass ? push_data_i : (head_valid ? mem_q[rd_ptr_q] : instr_q);
  assign push_ready_o = ready_q;
  assign count_o      = count_q;
  assign empty_o      = empty_q;

endmodule

// File: tb/tb_vinstr_queue.sv
// Directed self-checking bench for vinstr_queue (DW=128, DEPTH=4).
module tb_vinstr_queue;

  localparam int unsigned DW = 128;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             push_valid_i, push_fence_i, flush_i, pop_i, vector_idle_i;
  logic [DW-1:0]    push_data_i;
  logic             push_ready_o, valid_o, empty_o;
  logic [DW-1:0]    instr_o;
  logic [CNT_W-1:0] count_o;

  int tests = 0;
  int fails = 0;

  vinstr_queue #(.DW(DW), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid_i (push_valid_i),
    .push_data_i  (push_data_i),
    .push_fence_i (push_fence_i),
    .push_ready_o (push_ready_o),
    .flush_i      (flush_i),
    .valid_o      (valid_o),
    .instr_o      (instr_o),
    .pop_i        (pop_i),
    .vector_idle_i(vector_idle_i),
    .count_o      (count_o),
    .empty_o      (empty_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    push_valid_i  = 1'b0;
    push_fence_i  = 1'b0;
    push_data_i   = '0;
    flush_i       = 1'b0;
    pop_i         = 1'b0;
    vector_idle_i = 1'b0;
  endtask

  function automatic logic [DW-1:0] dat(input int base, input int k);
    return {32'(base), 64'h0, 32'(k)};
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_valid"}, DW'(valid_o), DW'(0));
    check_eq({pfx, "_ready"}, DW'(push_ready_o), DW'(1));
    check_eq({pfx, "_count"}, DW'(count_o), DW'(0));
    check_eq({pfx, "_empty"}, DW'(empty_o), DW'(1));
    check_eq({pfx, "_instr"}, instr_o, DW'(0));
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_reset_outputs("rst");

    // Fill A1..A4 without popping.
    for (int i = 1; i <= 4; i++) begin
      push_valid_i = 1'b1;
      push_data_i  = dat(32'hA, i);
      step();
      check_eq($sformatf("fill_count%0d", i), DW'(count_o), DW'(i));
      check_eq($sformatf("fill_ready%0d", i), DW'(push_ready_o), DW'(i < 4));
    end
    check_eq("fill_head", instr_o, dat(32'hA, 1));
    check_eq("fill_valid", DW'(valid_o), DW'(1));

    // Push offered while full alongside a pop: push refused, count 4 -> 3.
    push_valid_i = 1'b1;
    push_data_i  = dat(32'hEE, 0);
    pop_i        = 1'b1;
    step();
    check_eq("full_pp_count", DW'(count_o), DW'(3));
    check_eq("full_pp_ready", DW'(push_ready_o), DW'(1));
    push_valid_i = 1'b0;

    // Drain A2..A4 in order, one per cycle.
    for (int i = 2; i <= 4; i++) begin
      check_eq($sformatf("drain_valid%0d", i), DW'(valid_o), DW'(1));
      check_eq($sformatf("drain_data%0d", i), instr_o, dat(32'hA, i));
      step();
    end
    pop_i = 1'b0;
    check_eq("drain_empty", DW'(empty_o), DW'(1));
    check_eq("drain_valid_end", DW'(valid_o), DW'(0));

    // Wrap-around: D0 preloaded, then 10 push/pop pairs, then drain D10.
    push_valid_i = 1'b1;
    push_data_i  = dat(32'hD, 0);
    step();
    for (int k = 0; k < 10; k++) begin
      push_data_i = dat(32'hD, k + 1);
      pop_i       = 1'b1;
      check_eq($sformatf("wrap_data%0d", k), instr_o, dat(32'hD, k));
      step();
      check_eq($sformatf("wrap_count%0d", k), DW'(count_o), DW'(1));
    end
    push_valid_i = 1'b0;
    check_eq("wrap_last", instr_o, dat(32'hD, 10));
    step();
    pop_i = 1'b0;
    check_eq("wrap_empty", DW'(empty_o), DW'(1));

    // Fence: I1, FENCE, I2.
    push_valid_i = 1'b1;
    push_data_i  = dat(32'h1, 1);
    step();
    push_fence_i = 1'b1;
    push_data_i  = '0;
    step();
    push_fence_i = 1'b0;
    push_data_i  = dat(32'h1, 2);
    step();
    push_valid_i = 1'b0;
    check_eq("fence_count3", DW'(count_o), DW'(3));
    pop_i = 1'b1;
    check_eq("fence_i1", instr_o, dat(32'h1, 1));
    step();
    pop_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check_eq($sformatf("fence_hold_valid%0d", c), DW'(valid_o), DW'(0));
      check_eq($sformatf("fence_hold_count%0d", c), DW'(count_o), DW'(2));
      step();
    end
    vector_idle_i = 1'b1;
    check_eq("fence_rise_valid", DW'(valid_o), DW'(0));
    step();
    vector_idle_i = 1'b0;
    check_eq("fence_drop_count", DW'(count_o), DW'(1));
    check_eq("fence_i2_valid", DW'(valid_o), DW'(1));
    check_eq("fence_i2_data", instr_o, dat(32'h1, 2));
    pop_i = 1'b1;
    step();
    pop_i = 1'b0;
    check_eq("fence_empty", DW'(empty_o), DW'(1));

    // Flush with 3 entries and a concurrent push.
    push_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push_data_i = dat(32'hF, i);
      step();
    end
    flush_i     = 1'b1;
    push_data_i = dat(32'hF, 9);
    step();
    idle_inputs();
    check_eq("flush_count", DW'(count_o), DW'(0));
    check_eq("flush_empty", DW'(empty_o), DW'(1));
    check_eq("flush_valid", DW'(valid_o), DW'(0));

    // Reset while the FSM waits for idle on a head fence.
    push_valid_i = 1'b1;
    push_fence_i = 1'b1;
    step();
    idle_inputs();
    step();
    check_eq("pre_rst_count", DW'(count_o), DW'(1));
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("rst_fence");
    // FSM restarts in the arm state: an immediate idle must not drop yet.
    push_valid_i = 1'b1;
    push_fence_i = 1'b1;
    step();
    idle_inputs();
    vector_idle_i = 1'b1;
    step();
    check_eq("arm_after_rst_count", DW'(count_o), DW'(1));
    step();
    vector_idle_i = 1'b0;
    check_eq("drop_after_arm_count", DW'(count_o), DW'(0));

    // Push into an empty queue with a same-cycle pop.
    push_valid_i = 1'b1;
    push_data_i  = dat(32'hB, 0);
    pop_i        = 1'b1;
    #1;
`ifdef VINSTR_QUEUE_BYPASS_EN
    check_eq("byp_valid", DW'(valid_o), DW'(1));
    check_eq("byp_instr", instr_o, dat(32'hB, 0));
    step();
    idle_inputs();
    check_eq("byp_count", DW'(count_o), DW'(0));
`else
    check_eq("nobyp_valid", DW'(valid_o), DW'(0));
    step();
    idle_inputs();
    check_eq("nobyp_count", DW'(count_o), DW'(1));
    check_eq("nobyp_instr", instr_o, dat(32'hB, 0));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
